hazard_scoreboard: RTL

- Parametrised successor to the single-cycle load-use hazard unit.
- Tracks every in-flight register write with a per-register countdown of cycles until its result can be forwarded. Supports variable-latency producers: ALU, load, multi-cycle mul/div.
- Generates decode stall, redirect flush and ID/EX bubble, with optional no-forwarding mode and an external pipeline freeze.
- Sits beside the ID/EX boundary; drives the pipeline-register enables and clears.

---
 rtl/hazard_scoreboard.sv | 95 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard: counts down the cycles until each in-flight
// destination becomes forwardable and drives decode stall / flush / ID-EX bubble.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned MAX_LAT = 7,
  parameter int unsigned LATW    = 3,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned WB_LAT  = 3,
  parameter int unsigned CNTW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1_addr,
  input  logic [AW-1:0]   id_rs2_addr,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd_addr,
  input  logic            id_rd_we,
  input  logic [LATW-1:0] id_lat,
  input  logic            ex_pc_src,
  input  logic            ext_freeze,
  output logic            stall,
  output logic            flush_if_id,
  output logic            idex_bubble,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam logic [LATW-1:0] MAX_LAT_V = LATW'(MAX_LAT);
  localparam logic [LATW-1:0] WB_LAT_V  = LATW'(WB_LAT);
  localparam logic [LATW-1:0] ONE_V     = LATW'(1);

  logic [LATW-1:0] cnt     [NREG];
  logic [LATW-1:0] cnt_nxt [NREG];

  logic            haz1;
  logic            haz2;
  logic            issue;
  logic            do_load;
  logic [LATW-1:0] lat_clamped;
  logic [LATW-1:0] lat_src;
  logic [LATW:0]   lat_sum;
  logic [LATW-1:0] load_val;

  // Load value carries +1 for the ID->EX transfer, saturated to the counter range.
  always_comb begin
    lat_clamped = (id_lat > MAX_LAT_V) ? MAX_LAT_V : id_lat;
    lat_src     = (FWD_EN != 0) ? lat_clamped : WB_LAT_V;
    lat_sum     = {1'b0, lat_src} + 1'b1;
    load_val    = lat_sum[LATW] ? '1 : lat_sum[LATW-1:0];
  end

  // A count of 1 is forwardable into the coming EX cycle, so only >1 blocks.
  always_comb begin
    haz1        = id_valid & id_rs1_used & (id_rs1_addr != '0) & (cnt[id_rs1_addr] > ONE_V);
    haz2        = id_valid & id_rs2_used & (id_rs2_addr != '0) & (cnt[id_rs2_addr] > ONE_V);
    stall       = ~rst & (haz1 | haz2) & ~ex_pc_src;
    flush_if_id = ~rst & ex_pc_src;
    idex_bubble = stall | flush_if_id;
    issue       = id_valid & ~stall & ~ex_pc_src & ~ext_freeze;
    do_load     = issue & id_rd_we;
  end

  always_comb begin
    cnt_nxt[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (do_load && (id_rd_addr == AW'(r))) begin
        cnt_nxt[r] = load_val;
      end else if (cnt[r] != '0) begin
        cnt_nxt[r] = cnt[r] - 1'b1;
      end else begin
        cnt_nxt[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '{default: '0};
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_freeze) begin
      cnt <= cnt_nxt;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ex_pc_src && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
